// File: rtl/wb_dsp_bus_master.sv
// Wishbone B3 classic single-access master serving the DSP algorithm sequencer's
// memory requests, with response timeout, bounded retry and error reporting.
module wb_dsp_bus_master #(
  parameter int unsigned dw        = 32,
  parameter int unsigned aw        = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_GAP = 2
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          alg_start,
  input  logic [aw-1:0] alg_address,
  input  logic [3:0]    alg_selection,
  input  logic          alg_write,
  input  logic [dw-1:0] alg_data_wr,
  output logic [dw-1:0] alg_data_rd,
  output logic          active,
  output logic          alg_error,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  typedef enum logic [1:0] {StIdle, StBus, StRetryWait} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
  localparam logic [3:0] RtyMax  = 4'(MAX_RETRY);
  localparam logic [3:0] GapInit = 4'(RETRY_GAP);

  state_e        r_state, w_state_nxt;
  logic [7:0]    r_tmo, w_tmo_nxt;
  logic [3:0]    r_rty, w_rty_nxt;
  logic [3:0]    r_gap, w_gap_nxt;
  logic [aw-1:0] r_adr, w_adr_nxt;
  logic [dw-1:0] r_dat, w_dat_nxt;
  logic [3:0]    r_sel, w_sel_nxt;
  logic          r_we, w_we_nxt;
  logic          r_cyc, w_cyc_nxt;
  logic          r_active, w_active_nxt;
  logic          r_error, w_error_nxt;
  logic [dw-1:0] r_data_rd, w_data_rd_nxt;
  logic          w_abort;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= StIdle;
      r_tmo     <= '0;
      r_rty     <= '0;
      r_gap     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_active  <= 1'b0;
      r_error   <= 1'b0;
      r_data_rd <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo     <= w_tmo_nxt;
      r_rty     <= w_rty_nxt;
      r_gap     <= w_gap_nxt;
      r_adr     <= w_adr_nxt;
      r_dat     <= w_dat_nxt;
      r_sel     <= w_sel_nxt;
      r_we      <= w_we_nxt;
      r_cyc     <= w_cyc_nxt;
      r_active  <= w_active_nxt;
      r_error   <= w_error_nxt;
      r_data_rd <= w_data_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmo_nxt     = r_tmo;
    w_rty_nxt     = r_rty;
    w_gap_nxt     = r_gap;
    w_adr_nxt     = r_adr;
    w_dat_nxt     = r_dat;
    w_sel_nxt     = r_sel;
    w_we_nxt      = r_we;
    w_cyc_nxt     = r_cyc;
    w_active_nxt  = r_active;
    w_error_nxt   = r_error;
    w_data_rd_nxt = r_data_rd;
    w_abort       = 1'b0;

    case (r_state)
      StIdle: begin
        if (alg_start) begin
          w_adr_nxt    = alg_address;
          w_sel_nxt    = alg_selection;
          w_we_nxt     = alg_write;
          w_dat_nxt    = alg_data_wr;
          w_cyc_nxt    = 1'b1;
          w_active_nxt = 1'b1;
          w_error_nxt  = 1'b0;
          w_rty_nxt    = '0;
          w_tmo_nxt    = '0;
          w_state_nxt  = StBus;
        end
      end
      StBus: begin
        // Response priority: err > ack > rty > timeout.
        if (wb_err_i) begin
          w_abort = 1'b1;
        end else if (wb_ack_i) begin
          w_cyc_nxt    = 1'b0;
          w_active_nxt = 1'b0;
          if (!r_we) w_data_rd_nxt = wb_dat_i;
          w_state_nxt  = StIdle;
        end else if (wb_rty_i) begin
          if (r_rty == RtyMax) begin
            w_abort = 1'b1;
          end else begin
            w_cyc_nxt   = 1'b0;
            w_rty_nxt   = r_rty + 4'd1;
            w_gap_nxt   = GapInit;
            w_state_nxt = StRetryWait;
          end
        end else if (r_tmo == TmoLast) begin
          w_abort = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      StRetryWait: begin
        w_gap_nxt = r_gap - 4'd1;
        if (r_gap == 4'd1) begin
          w_cyc_nxt   = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = StBus;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_abort) begin
      w_cyc_nxt     = 1'b0;
      w_active_nxt  = 1'b0;
      w_error_nxt   = 1'b1;
      w_data_rd_nxt = '0;
      w_state_nxt   = StIdle;
    end
  end

  assign alg_data_rd = r_data_rd;
  assign active      = r_active;
  assign alg_error   = r_error;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;

endmodule

// File: doc/wb_dsp_bus_master.md
Name: wb_dsp_bus_master

Overview:
- Wishbone B3 classic single-access master that services the DSP algorithm/equation state machines' memory requests (alg_* request interface) and returns read data.
- Sits between the algorithm sequencer and the system Wishbone fabric. Adds a response timeout, bounded retry and an error report.
- The requester issues a one-cycle start, watches active, and consumes alg_data_rd on the first cycle active is low.

Parameters:
- dw, 32, data width
- aw, 32, address width
- TIMEOUT, 255, cycles to wait for ack/err/rty before abort (8-bit counter, 1..255)
- MAX_RETRY, 3, rty responses tolerated before error (0..15)
- RETRY_GAP, 2, idle cycles between retry attempts (1..15)

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  reset, asynchronous assert, active-low
- alg_start  in  1  one-cycle request strobe
- alg_address  in  aw  request byte address
- alg_selection  in  4  byte selects
- alg_write  in  1  1=write, 0=read
- alg_data_wr  in  dw  write data
- alg_data_rd  out  dw  read data, registered
- active  out  1  transaction in progress
- alg_error  out  1  last transaction ended in err/timeout/retry exhaustion
- wb_adr_o  out  aw  Wishbone address
- wb_dat_o  out  dw  Wishbone write data
- wb_sel_o  out  4  Wishbone select
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_cti_o  out  3  constant 3'b000 (classic)
- wb_bte_o  out  2  constant 2'b00
- wb_dat_i  in  dw  Wishbone read data
- wb_ack_i  in  1  Wishbone ack
- wb_err_i  in  1  Wishbone error
- wb_rty_i  in  1  Wishbone retry

Behaviour:
- Reset (wb_rst_n low, asynchronous): state=IDLE; all outputs 0 (alg_data_rd, active, alg_error, wb_* outputs); counters 0. Reset mid-transaction drops cyc/stb immediately. No completion is reported.
- All outputs registered. States: IDLE, BUS, RETRY_WAIT.
- IDLE: at an edge with alg_start=1:
  - latch alg_address/selection/write/data_wr into wb_adr_o/sel_o/we_o/dat_o;
  - set cyc=stb=1 and active=1; clear alg_error, retry count and timeout count;
  - go to BUS.
  - Net effect: active is high the cycle after the start pulse.
- BUS: response priority err > ack > rty > timeout.
  - wb_err_i: cyc=stb=0, active=0, alg_error=1, alg_data_rd=0, go to IDLE.
  - wb_ack_i: cyc=stb=0, active=0. A read loads alg_data_rd<=wb_dat_i; a write leaves alg_data_rd unchanged. Go to IDLE.
  - wb_rty_i with retry count < MAX_RETRY: cyc=stb=0, increment retry count, load gap counter=RETRY_GAP, go to RETRY_WAIT; active stays 1.
  - wb_rty_i with retry count == MAX_RETRY: finish as err.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no response, finish as err.
- RETRY_WAIT: decrement the gap counter. On reaching 0, reassert cyc=stb=1 with the same latched request, clear the timeout counter, and go to BUS.
- Completion: active falls on the same edge that alg_data_rd/alg_error update, so data is valid in the first cycle active=0. Minimum latency from start edge to active low is 2 edges (zero-wait-state ack).
- alg_start while active=1 is ignored, with no queueing. alg_start in the same cycle active falls is also ignored, because the state is not yet IDLE. A start is accepted one cycle after completion at the earliest.
- Request inputs are sampled only at accept; changes during a transaction have no effect.
- wb_* address/data/sel/we hold their values after completion until the next accept.
- wb_cti_o and wb_bte_o are tied constant.

Test Plan:
- Read, ack after 3 wait cycles: start, adr=0x100, sel=F, wb_dat_i=0xCAFEF00D -> cyc/stb high 4 cycles, active low the edge after ack, alg_data_rd=0xCAFEF00D, alg_error=0.
- Write, zero-wait ack: start, adr=0x204, data=0x12345678, sel=4'h3 -> wb_we_o=1, wb_dat_o=0x12345678, wb_sel_o=3, cyc high exactly 1 cycle, alg_data_rd unchanged.
- Retry: slave rty twice then ack with MAX_RETRY=3, RETRY_GAP=2 -> two 2-cycle cyc-low gaps with same address, active high throughout, final alg_error=0, data captured.
- Retry exhaustion and err: rty 4 times -> alg_error=1, alg_data_rd=0 after 4th rty. Separately, err with ack in the same cycle -> alg_error=1.
- Timeout with TIMEOUT=8 and a silent slave -> cyc drops after 8 BUS cycles, alg_error=1. Next start clears alg_error.
- Async reset and start-while-busy: wb_rst_n low mid-BUS -> cyc/stb/active 0 without a clock edge. A second alg_start during active is ignored, giving exactly one bus cycle.
